// File: rtl/multicore_perf_display.sv
// Multi-core completion monitor: per-core done/cycle capture, saturating cycle
// counter, and a tear-free multiplexed hex display of a selectable value.

module mpd_core_track #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             done,
  input  logic [CNT_W-1:0] cnt,
  output logic             seen,
  output logic [CNT_W-1:0] cycles
);
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  always_comb begin
    seen_d   = seen_q | done;
    cycles_d = (done && !seen_q) ? cnt : cycles_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      seen_q   <= seen_d;
      cycles_q <= cycles_d;
    end
  end

  assign seen   = seen_q;
  assign cycles = cycles_q;
endmodule

module multicore_perf_display #(
  parameter int N_CORES       = 4,
  parameter int RESULT_W      = 8,
  parameter int DIGITS        = 4,
  parameter int REFRESH_TICKS = 120000,
  parameter int BLANK_LZ      = 1,
  parameter int SEL_W         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CORES-1:0]           done,
  input  logic [N_CORES*RESULT_W-1:0]  result_flat,
  input  logic [1:0]                   mode,
  input  logic [SEL_W-1:0]             core_sel,
  output logic                         all_done,
  output logic [DIGITS-1:0]            anode,
  output logic [6:0]                   segments
);
  localparam int CNT_W = 4 * DIGITS;
  localparam int SUM_W = RESULT_W + $clog2(N_CORES);
  localparam int TMR_W = $clog2(REFRESH_TICKS);
  localparam int IDX_W = $clog2(DIGITS);

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1111110;  4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;  4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;  4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;  4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;  4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;  default: hex7 = 7'b1000111;
    endcase
  endfunction

  logic [N_CORES-1:0]            seen;
  logic [N_CORES-1:0][CNT_W-1:0] cycles;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              all_done_q, all_done_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  snap_q, snap_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;

  logic [CNT_W-1:0]  disp;
  logic [IDX_W-1:0]  idx_nxt;
  logic [CNT_W-1:0]  snap_nxt;
  logic [3:0]        nib;
  logic              hi_zero;
  logic              adv;

  for (genvar g = 0; g < N_CORES; g++) begin : g_core
    mpd_core_track #(.CNT_W(CNT_W)) u_trk (
      .clk    (clk),
      .reset  (reset),
      .done   (done[g]),
      .cnt    (cnt_q),
      .seen   (seen[g]),
      .cycles (cycles[g])
    );
  end

  always_comb begin
    // Stop on the edge all_done rises so the frozen value is last-done + 1.
    cnt_d = cnt_q;
    if (!(&seen) && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    all_done_d = &seen;
    sum_d = '0;
    for (int i = 0; i < N_CORES; i++)
      sum_d = sum_d + SUM_W'(result_flat[i*RESULT_W +: RESULT_W]);
  end

  always_comb begin
    disp = '0;
    case (mode)
      2'd0: disp = CNT_W'(sum_q);
      2'd1: disp = cnt_q;
      2'd2: for (int i = 0; i < N_CORES; i++)
              if (32'(core_sel) == i) disp = cycles[i];
      default: disp = CNT_W'(seen);
    endcase
  end

  always_comb begin
    adv      = (tmr_q == TMR_W'(REFRESH_TICKS - 1));
    tmr_d    = adv ? '0 : tmr_q + 1'b1;
    idx_nxt  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    snap_nxt = (idx_nxt == '0) ? disp : snap_q;
    nib      = 4'h0;
    hi_zero  = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      if (32'(idx_nxt) == k) begin
        nib     = snap_nxt[4*k +: 4];
        hi_zero = ((snap_nxt >> (4*k)) == '0);
      end
    idx_d   = idx_q;
    snap_d  = snap_q;
    anode_d = anode_q;
    seg_d   = seg_q;
    // Anode and segments are computed from the post-advance index/snapshot
    // so both change on the same edge.
    if (adv) begin
      idx_d   = idx_nxt;
      snap_d  = snap_nxt;
      anode_d = ~(DIGITS'(1) << idx_nxt);
      seg_d   = ((BLANK_LZ != 0) && idx_nxt != '0 && hi_zero) ? 7'b0 : hex7(nib);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      all_done_q <= 1'b0;
      sum_q      <= '0;
      snap_q     <= '0;
      tmr_q      <= '0;
      idx_q      <= IDX_W'(DIGITS - 1);
      anode_q    <= '1;
      seg_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      all_done_q <= all_done_d;
      sum_q      <= sum_d;
      snap_q     <= snap_d;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
    end
  end

  assign all_done = all_done_q;
  assign anode    = anode_q;
  assign segments = seg_q;
endmodule

// File: tb/tb_multicore_perf_display.sv
// Bench: random-result directed sequence checked against a time-based model of
// the counter, done capture and display scan, plus fixed digit patterns.

module tb_multicore_perf_display;
  localparam int RT = 4;
  localparam int DG = 4;
  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
  localparam logic [6:0] SF = 7'b1000111, SB = 7'b0000000;

  logic        clk = 1'b0, reset = 1'b0;
  logic [3:0]  done = '0;
  logic [31:0] result_flat = '0;
  logic [1:0]  mode = 2'd1;
  logic [3:0]  core_sel = '0;
  logic        all_done;
  logic [3:0]  anode;
  logic [6:0]  segments;

  logic [1:0]  done2 = '0;
  logic [15:0] res2 = '0;
  logic [1:0]  mode2 = 2'd0;
  logic [3:0]  sel2 = '0;
  logic        all_done2;
  logic [1:0]  an2;
  logic [6:0]  seg2;

  multicore_perf_display #(.N_CORES(4), .RESULT_W(8), .DIGITS(4), .REFRESH_TICKS(RT),
    .BLANK_LZ(1), .SEL_W(4)) dut (
    .clk(clk), .reset(reset), .done(done), .result_flat(result_flat), .mode(mode),
    .core_sel(core_sel), .all_done(all_done), .anode(anode), .segments(segments));

  multicore_perf_display #(.N_CORES(2), .RESULT_W(8), .DIGITS(2), .REFRESH_TICKS(2),
    .BLANK_LZ(0), .SEL_W(4)) dut2 (
    .clk(clk), .reset(reset), .done(done2), .result_flat(res2), .mode(mode2),
    .core_sel(sel2), .all_done(all_done2), .anode(an2), .segments(seg2));

  always #5 clk = ~clk;

  int checks = 0, passed = 0;

  // Reference model state (cycles since reset release drive the scan position).
  int m_t, m_cnt, m_sum, m_snap, m_idx;
  int m_cc[4];
  logic [3:0] m_seen;
  bit m_all, m_valid, m_adv;

  function automatic logic [6:0] enc(input int h);
    logic [6:0] t[16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                          7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                          7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                          7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return t[h & 15];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic wait_expired(input string tag);
    checks++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic model_reset();
    m_t = 0; m_cnt = 0; m_sum = 0; m_snap = 0; m_idx = 0;
    m_seen = '0; m_all = 0; m_valid = 0; m_adv = 0;
    foreach (m_cc[i]) m_cc[i] = 0;
  endtask

  function automatic int disp_model();
    case (mode)
      2'd0: return m_sum & 32'hFFFF;
      2'd1: return m_cnt;
      2'd2: return (core_sel < 4) ? m_cc[core_sel] : 0;
      default: return int'(m_seen);
    endcase
  endfunction

  task automatic model_edge();
    int dv;
    dv = disp_model();
    m_t++;
    m_adv = (m_t % RT == 0);
    if (m_adv) begin
      m_idx = ((m_t / RT) - 1) % DG;
      if (m_idx == 0) m_snap = dv;
      m_valid = 1;
    end
    for (int i = 0; i < 4; i++) if (done[i] && !m_seen[i]) m_cc[i] = m_cnt;
    if (m_seen != 4'hF && m_cnt < 16'hFFFF) m_cnt++;
    m_all = (m_seen == 4'hF);
    m_seen = m_seen | done;
    m_sum = 0;
    for (int i = 0; i < 4; i++) m_sum += int'(result_flat[8*i +: 8]);
  endtask

  task automatic check_model();
    logic [3:0] ea;
    logic [6:0] es;
    ea = 4'hF; es = '0;
    if (m_valid) begin
      ea = ~(4'b0001 << m_idx);
      es = (m_idx > 0 && (m_snap >> (4*m_idx)) == 0) ? 7'b0 : enc(m_snap >> (4*m_idx));
    end
    chk("all_done", 32'(all_done), 32'(m_all));
    chk("anode", 32'(anode), 32'(ea));
    chk("segments", 32'(segments), 32'(es));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic capture(output logic [3:0][6:0] s);
    s = '0;
    for (int n = 0; n < DG*RT; n++) begin
      tick();
      for (int k = 0; k < 4; k++) if (anode == ~(4'b0001 << k)) s[k] = segments;
    end
  endtask

  task automatic show(input string tag, input logic [1:0] m, input logic [3:0] sel,
                      input logic [3:0][6:0] ex);
    logic [3:0][6:0] s;
    mode = m; core_sel = sel;
    tick_n(2*DG*RT);
    capture(s);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_d%0d", tag, k), 32'(s[k]), 32'(ex[k]));
  endtask

  task automatic wait_idx(input int idx, input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (!(m_adv && m_idx == idx) && n < 40);
    if (!(m_adv && m_idx == idx)) wait_expired(tag);
  endtask

  task automatic d2_check(input string tag, input logic [6:0] ex);
    for (int n = 0; n < 8; n++) begin
      tick();
      chk({tag, "_anode"}, 32'(an2 == 2'b10 || an2 == 2'b01), 32'd1);
      chk({tag, "_seg"}, 32'(seg2), 32'(ex));
    end
  endtask

  initial begin
    logic [3:0][6:0] s;
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(segments), 32'h0);
    chk("rst_all_done", 32'(all_done), 32'h0);
    reset = 1'b1;

    // Done capture: core 2 at 0x10, the rest together at 0x20.
    n = 0;
    while (m_cnt != 16 && n < 100) begin result_flat = $urandom; tick(); n++; end
    if (m_cnt != 16) wait_expired("cnt_0x10");
    done[2] = 1'b1;
    tick_n(3);
    done[2] = 1'b0;
    n = 0;
    while (m_cnt != 32 && n < 100) begin result_flat = $urandom; tick(); n++; end
    if (m_cnt != 32) wait_expired("cnt_0x20");
    done = 4'b1011;
    tick();
    chk("all_done_lag", 32'(all_done), 32'd0);
    tick();
    chk("all_done_rise", 32'(all_done), 32'd1);
    done = '0;
    d2_check("d2_zero_noblank", S0);
    mode2 = 2'd1;

    show("cc2", 2'd2, 4'd2, {SB, SB, S1, S0});
    show("cc0", 2'd2, 4'd0, {SB, SB, S2, S0});
    show("sel_oob", 2'd2, 4'd7, {SB, SB, SB, S0});
    show("seen", 2'd3, 4'd0, {SB, SB, SB, SF});
    show("frozen", 2'd1, 4'd0, {SB, SB, S2, S1});

    // Mode change mid-scan only takes effect at the next snapshot.
    result_flat = {8'h02, 8'h01, 8'hFF, 8'hFF};
    wait_idx(1, "idx1");
    mode = 2'd0;
    wait_idx(2, "idx2");
    chk("lag_d2", 32'(segments), 32'(SB));
    wait_idx(3, "idx3");
    chk("lag_d3", 32'(segments), 32'(SB));
    wait_idx(0, "idx0");
    chk("new_d0", 32'(segments), 32'(S1));
    capture(s);
    chk("sum_d3", 32'(s[3]), 32'(SB));
    chk("sum_d2", 32'(s[2]), 32'(S2));
    chk("sum_d1", 32'(s[1]), 32'(S0));
    chk("sum_d0", 32'(s[0]), 32'(S1));

    result_flat = '0;
    show("zero", 2'd0, 4'd0, {SB, SB, SB, S0});

    tick_n(300);
    d2_check("d2_sat", SF);

    // Reset between edges clears outputs before the next clock.
    result_flat = $urandom;
    mode = 2'd1;
    tick_n(7);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_anode", 32'(anode), 32'hF);
    chk("mid_rst_seg", 32'(segments), 32'h0);
    chk("mid_rst_all_done", 32'(all_done), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    tick_n(24);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
